// File: rtl/set_mode_controller.sv
// rtl/set_mode_controller.sv - set-mode FSM for a BCD clock: key sync/press detect, field loads, timeout, blink
// Optional feature macro: SET_MODE_CONTROLLER_DEBOUNCE_EN (builds the per-key debounce counters).
module set_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 500000000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic       ALARM_SEL,
  input  logic [7:0] SET_IN,
  output logic       SET_TIME,
  output logic       SET_ALARM,
  output logic [1:0] FIELD_SEL,
  output logic       LOAD_STB,
  output logic [7:0] LOAD_VAL,
  output logic       LOAD_ERR,
  output logic       DISP_SEL,
  output logic       BLINK
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_T_HOUR = 3'd1,
    S_T_MIN  = 3'd2,
    S_A_HOUR = 3'd3,
    S_A_MIN  = 3'd4
  } state_t;

  // Index 0 is KEY0 (mode), index 1 is KEY1 (load). Keys are active-low.
  logic [1:0] key_raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] lvl_q;
  logic [1:0] press_q;

  assign key_raw = {KEY1, KEY0};

  // Two-flop synchronizer. Resets to "pressed" so a key held through reset
  // must be seen released before it can produce a press.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef SET_MODE_CONTROLLER_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [1:0][DW-1:0] db_cnt_q;

  // Debounce: level follows the synchronized key only after it has differed for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      db_cnt_q <= '0;
      lvl_q    <= 2'b00;
      press_q  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        press_q[i] <= 1'b0;
        if (sync2_q[i] == lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          db_cnt_q[i] <= '0;
          lvl_q[i]    <= sync2_q[i];
          press_q[i]  <= ~sync2_q[i];
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  // No debounce: press is the registered falling edge of the synchronized key.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      lvl_q   <= 2'b00;
      press_q <= 2'b00;
    end else begin
      lvl_q   <= sync2_q;
      press_q <= lvl_q & ~sync2_q;
    end
  end
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] to_cnt_q;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  logic          stb_q, stb_d, err_q, err_d;
  logic [7:0]    load_val_q, val_d;
  logic          set_time_q, set_alarm_q;
  logic [1:0]    field_q;
  logic          press0, press1, is_hour, timeout_hit;

  // Packed BCD compares like decimal once both nibbles are valid digits.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max_v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max_v);
  endfunction

  assign press0      = press_q[0];
  assign press1      = press_q[1] & ~press_q[0];  // mode key wins a tie
  assign is_hour     = (state_q == S_T_HOUR) || (state_q == S_A_HOUR);
  assign timeout_hit = (state_q != S_RUN) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Next-state and load decision.
  always_comb begin
    state_d = state_q;
    stb_d   = 1'b0;
    err_d   = 1'b0;
    val_d   = load_val_q;
    if (state_q == S_RUN) begin
      if (press0) state_d = ALARM_SEL ? S_A_HOUR : S_T_HOUR;
    end else if (timeout_hit) begin
      state_d = S_RUN;
    end else if (press0) begin
      case (state_q)
        S_T_HOUR: state_d = S_T_MIN;
        S_A_HOUR: state_d = S_A_MIN;
        default:  state_d = S_RUN;
      endcase
    end else if (press1) begin
      if (bcd_ok(SET_IN, is_hour ? 8'h23 : 8'h59)) begin
        stb_d = 1'b1;
        val_d = SET_IN;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State and output registers; outputs decode the next state so they move with it.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_RUN;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      load_val_q  <= 8'h00;
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      field_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
      load_val_q  <= val_d;
      set_time_q  <= (state_d == S_T_HOUR) || (state_d == S_T_MIN);
      set_alarm_q <= (state_d == S_A_HOUR) || (state_d == S_A_MIN);
      field_q     <= ((state_d == S_T_HOUR) || (state_d == S_A_HOUR)) ? 2'b01 :
                     ((state_d == S_T_MIN)  || (state_d == S_A_MIN))  ? 2'b10 : 2'b00;
    end
  end

  // Idle timeout: restarts on entry, on state change and on every press.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      to_cnt_q <= '0;
    end else if ((state_d == S_RUN) || (state_d != state_q) || (press_q != 2'b00)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Blink generator: restarts low on every state change, idle in RUN.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if ((state_d == S_RUN) || (state_d != state_q)) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q <= '0;
      blink_q     <= ~blink_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign SET_TIME  = set_time_q;
  assign SET_ALARM = set_alarm_q;
  assign DISP_SEL  = set_alarm_q;
  assign FIELD_SEL = field_q;
  assign LOAD_STB  = stb_q;
  assign LOAD_ERR  = err_q;
  assign LOAD_VAL  = load_val_q;
  assign BLINK     = blink_q;

endmodule

// File: doc/set_mode_controller.md
SET_MODE_CONTROLLER -- requirements
Module: set_mode_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of stable CLOCK_50 cycles a key must hold before it counts as debounced (10 ms).
REQ-002 Parameter TIMEOUT_CYCLES, default 500000000, is the number of idle CLOCK_50 cycles in a set state before auto-exit (10 s).
REQ-003 Parameter BLINK_CYCLES, default 12500000, is the half-period of BLINK in CLOCK_50 cycles.
REQ-004 CLOCK_50  in  1  system clock; the single clock; all logic on rising edge.
REQ-005 RESET  in  1  asynchronous, active-high reset.
REQ-006 KEY0  in  1  mode button, active-low, asynchronous to CLOCK_50.
REQ-007 KEY1  in  1  load button, active-low, asynchronous to CLOCK_50.
REQ-008 ALARM_SEL  in  1  0 selects time setting, 1 selects alarm setting; sampled only on entry from RUN.
REQ-009 SET_IN  in  8  BCD value {tens[7:4], ones[3:0]} to load.
REQ-010 SET_TIME  out  1  high in T_HOUR or T_MIN.
REQ-011 SET_ALARM  out  1  high in A_HOUR or A_MIN.
REQ-012 FIELD_SEL  out  2  00 none, 01 hours, 10 minutes; 11 never driven.
REQ-013 LOAD_STB  out  1  one-cycle load strobe to the clock datapath.
REQ-014 LOAD_VAL  out  8  registered BCD value; valid while LOAD_STB high.
REQ-015 LOAD_ERR  out  1  one-cycle pulse when a load is rejected.
REQ-016 DISP_SEL  out  1  1 = display shows alarm registers; equals SET_ALARM.
REQ-017 BLINK  out  1  square wave for the field being edited; 0 in RUN.

Function
REQ-018 KEY0/KEY1 SHALL each pass a 2-flop synchronizer before any other use.
REQ-019 A press event SHALL be a one-cycle internal pulse on the debounced high-to-low transition; release SHALL generate nothing.
REQ-020 FSM states SHALL be RUN, T_HOUR, T_MIN, A_HOUR, A_MIN.
REQ-021 KEY0 press in RUN SHALL go to T_HOUR if ALARM_SEL=0, else A_HOUR, on the edge where the press pulse is high.
REQ-022 KEY0 press SHALL advance T_HOUR->T_MIN->RUN and A_HOUR->A_MIN->RUN.
REQ-023 KEY1 press in RUN SHALL be ignored (no strobe, no error).
REQ-024 KEY1 press in an hour state SHALL accept SET_IN iff both nibbles are BCD and value <= 0x23; minute states accept iff BCD and <= 0x59.
REQ-025 Accepted load: LOAD_STB=1 and LOAD_VAL=SET_IN exactly one cycle after the press pulse; state unchanged.
REQ-026 Rejected load: LOAD_ERR=1 for one cycle at the same latency; LOAD_STB stays 0; LOAD_VAL holds previous value.
REQ-027 KEY0 and KEY1 press pulses in the same cycle: KEY0 acts, KEY1 is dropped.
REQ-028 ALARM_SEL changes while not in RUN SHALL be ignored.
REQ-029 A timeout counter SHALL clear on entry to a set state and on any press event; reaching TIMEOUT_CYCLES-1 SHALL force RUN without strobe.
REQ-030 FIELD_SEL SHALL be 01 in *_HOUR, 10 in *_MIN, 00 in RUN; all state outputs registered, changing the cycle after the transition edge.
REQ-031 BLINK SHALL toggle every BLINK_CYCLES in set states and restart low on every state change.

Reset
REQ-032 RESET high SHALL immediately force RUN, all outputs 0, LOAD_VAL 0x00, and clear debounce, timeout and blink counters, even mid-debounce or mid-strobe.
REQ-033 A key held low across reset release SHALL NOT generate a press event until released and pressed again.

Configuration
REQ-034 Macro SET_MODE_CONTROLLER_DEBOUNCE_EN defined: REQ-001 debounce counters are built; press pulse fires DEBOUNCE_CYCLES+2 cycles after a stable key edge.
REQ-035 Macro SET_MODE_CONTROLLER_DEBOUNCE_EN undefined: no debounce counters; press pulse fires on the synchronized falling edge, 3 cycles after the key edge; DEBOUNCE_CYCLES unused.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=100, BLINK_CYCLES=8)
REQ-036 ALARM_SEL=0, KEY0 press x3 -> T_HOUR (SET_TIME=1, FIELD_SEL=01), T_MIN (FIELD_SEL=10), RUN (all 0).
REQ-037 In T_HOUR, SET_IN=0x23, KEY1 press -> LOAD_STB one cycle, LOAD_VAL=0x23; SET_IN=0x24 -> LOAD_ERR one cycle, LOAD_VAL stays 0x23.
REQ-038 ALARM_SEL=1, KEY0 press, then ALARM_SEL=0 -> A_HOUR, SET_ALARM=1, DISP_SEL=1; KEY1 with SET_IN=0x5A in A_MIN -> LOAD_ERR.
REQ-039 KEY0 glitch low 2 cycles (with _EN) -> no state change; KEY0 and KEY1 pulses same cycle in T_MIN -> RUN, no LOAD_STB.
REQ-040 Enter T_HOUR, no keys for 100 cycles -> RUN, no strobe; RESET asserted during LOAD_STB -> all outputs 0 that cycle.
